// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared encodings for the multicycle RV32I control path: FSM state enum,
// opcode constants, ALUOp and ALUControl codes, and datapath mux selects.
// No ports; imported by the controller, its ALU decoder and the bench.
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    // Opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUOp: what the FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // ALUControl: what the ALU itself sees
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Memory address select
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    // Result select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by an opcode; R-type and unknown opcodes
    // fall back to the I format (the immediate is unused for them).
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the multicycle controller and its datapath.
//   master : controller side (drives control strobes and counters,
//            receives instruction fields, Zero and mem_ready)
//   slave  : datapath side (the mirror image)
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    // Datapath -> controller
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        mem_ready;
    // Controller -> datapath
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        illegal;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               illegal, cycle_count, instr_count
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               illegal, cycle_count, instr_count
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Purely combinational: turns the FSM's ALUOp plus instruction fields into
// the ALU operation code.
//   i_alu_op       : add / sub / decode-from-funct request
//   i_funct3       : instruction bits [14:12]
//   i_op5          : opcode bit 5 (1 = register-register form)
//   i_funct7b5     : instruction bit 30
//   o_alu_control  : ALU operation
// -----------------------------------------------------------------------------
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  aluop_t     i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // bit 30 only means subtract for the R-type form; for
                    // addi it is just part of the immediate.
                    3'b000:  o_alu_control = ({i_op5, i_funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Main control FSM of the multicycle RV32I core. Steps the shared datapath
// through Fetch/Decode/Execute/Memory/Writeback, one state per cycle, and
// stalls in FETCH, MEMREAD and MEMWRITE until mem_ready.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low
//   bus   : multicycle_controller_if.master (instruction fields, Zero,
//           mem_ready in; control strobes, illegal, perf counters out)
// Optional build macro: MC_CTRL_PERF_EN enables cycle_count/instr_count;
// without it both ports read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    state_t     r_state;
    state_t     w_next_state;

    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_imm_src;
    aluop_t     w_alu_op;
    logic       w_illegal;
    logic [2:0] w_alu_control;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Moore-style decodes (plus the mem_ready / Zero gates)
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_adr_src    = ADR_PC;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_imm_src    = IMM_I;
        w_alu_op     = ALUOP_ADD;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC + 4 goes straight from the ALU into the PC register.
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm: branch target parked in ALUOut for BEQ.
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                w_imm_src   = imm_src_of(bus.op);
                case (bus.op)
                    OP_LOAD,
                    OP_STORE:  w_next_state = S_MEMADR;
                    OP_RTYPE:  w_next_state = S_EXECUTER;
                    OP_ITYPE:  w_next_state = S_EXECUTEI;
                    OP_BRANCH: w_next_state = S_BEQ;
                    OP_JAL:    w_next_state = S_JAL;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = ADR_ALUOUT;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole access, not just the last cycle.
                w_adr_src   = ADR_ALUOUT;
                w_mem_write = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                // rs1 - rs2 sets Zero; ALUOut still holds the target from DECODE.
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_result_src = RES_ALUOUT;
                w_pc_write   = bus.Zero;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC <- target (ALUOut) while the ALU forms OldPC + 4 for rd.
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (bus.funct3),
        .i_op5         (bus.op[5]),
        .i_funct7b5    (bus.funct7b5),
        .o_alu_control (w_alu_control)
    );

    // The state register already sits in FETCH while reset is low, but FETCH
    // itself can raise IRWrite/PCWrite on mem_ready, so every write enable is
    // additionally qualified by reset.
    assign bus.PCWrite    = w_pc_write  & reset;
    assign bus.IRWrite    = w_ir_write  & reset;
    assign bus.MemWrite   = w_mem_write & reset;
    assign bus.RegWrite   = w_reg_write & reset;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.ALUControl = w_alu_control;
    assign bus.illegal    = w_illegal;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instr_count;
    logic        w_instr_done;

    // An instruction retires whenever the FSM re-enters FETCH from another
    // state; this includes the illegal-opcode exit from DECODE.
    assign w_instr_done = (r_state != S_FETCH) && (w_next_state == S_FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_instr_done) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign bus.cycle_count = r_cycle_count;
    assign bus.instr_count = r_instr_count;
`else
    assign bus.cycle_count = 32'd0;
    assign bus.instr_count = 32'd0;
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core variant. It sequences the shared datapath (one ALU, one unified instruction/data memory port, instruction register, PC register) across Fetch, Decode, Execute, Memory and Writeback steps, one state per cycle. It also stalls on a memory-ready handshake. It replaces the combinational `control_unit` when the core is built around `data_path`'s multicycle sibling.

## Interface
- Parameters: none. Encodings are fixed in the shared package.
- `clk` input 1: core clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `op` input 7: instruction bits [6:0] taken from the instruction register.
- `funct3` input 3: instruction bits [14:12].
- `funct7b5` input 1: instruction bit 30.
- `Zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: instruction-register and OldPC enable.
- `RegWrite` output 1: register-file write enable.
- `ResultSrc` output 2: result select (00 = ALUOut, 01 = Data, 10 = ALUResult).
- `ALUSrcA` output 2: ALU A select (00 = PC, 01 = OldPC, 10 = rs1).
- `ALUSrcB` output 2: ALU B select (00 = rs2, 01 = imm, 10 = constant 4).
- `ImmSrc` output 2: immediate format (00 = I, 01 = S, 10 = B, 11 = J).
- `ALUControl` output 3: ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt).
- `illegal` output 1: one-cycle pulse in Decode for an unsupported opcode.
- `cycle_count` output 32: performance counter (see Configuration).
- `instr_count` output 32: performance counter (see Configuration).

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- FETCH:
  - AdrSrc=0; ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
  - While `mem_ready`=0: stay in FETCH with IRWrite=PCWrite=0.
  - When `mem_ready`=1: pulse IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=add. This computes the branch target.
  - ImmSrc is decoded from `op`.
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH with `illegal`=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until `mem_ready`, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=`Zero`. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Then ALUWB.
- ALU decode (ALUOp=funct):
  - funct3 000 → sub when {op[5],funct7b5}=11, otherwise add.
  - funct3 010 → slt.
  - funct3 110 → or.
  - funct3 111 → and.
  - any other funct3 → add.
- Every signal not listed for a state is 0.

## Timing
- Outputs are Moore decodes of the state register. The exceptions are IRWrite and PCWrite in FETCH and MEMWRITE's exit, which are also gated by `mem_ready`, and PCWrite in BEQ, which is gated by `Zero`.
- Latency with `mem_ready` tied high:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type, I-type ALU | 4 |
  | beq | 3 |
  | jal | 4 |

  Each memory wait cycle adds 1.
- Reset asserted (`reset`=0), at any time including mid-instruction:
  - state becomes FETCH immediately (asynchronous);
  - all write enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0;
  - counters clear.
- During reset, the other outputs take their FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, ImmSrc=00, `illegal`=0.
- Reset release: the first FETCH evaluation happens on the first rising edge after deassertion.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `cycle_count` increments every cycle out of reset.
  - `instr_count` increments on each transition into FETCH from a final state.
  - The transition from DECODE to FETCH on an illegal opcode also counts.
  - Both counters wrap modulo 2^32.
- `MC_CTRL_PERF_EN` undefined: both ports exist and are tied to 0, and no counter flops are built.

## Structure
- Package `rv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - ALUOp codes (00 add, 01 sub, 10 funct);
  - ALUControl codes;
  - the mux-select constants.
- Sub-module `alu_decoder` is combinational: ALUOp, funct3, op[5], funct7b5 → ALUControl.
- The FSM and the counters live in the top level.

## Test plan
- `reset`=0 held mid-MEMREAD, then released → state FETCH; MemWrite, RegWrite, IRWrite and PCWrite are 0 throughout reset.
- `add x3,x1,x2` (0x002081B3), `mem_ready`=1 → FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000; RegWrite on cycle 4.
- `lw` (op 0000011) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; RegWrite with ResultSrc=01 exactly once.
- `beq` with `Zero`=1, then again with `Zero`=0 → PCWrite=1 in BEQ, then PCWrite=0; 3 cycles each.
- `sub` (funct7b5=1, op 0110011) gives ALUControl=001; `addi` (op 0010011) with funct7b5=1 gives 000.
- Opcode 0x7F → `illegal` pulses in DECODE and the FSM returns to FETCH. With `MC_CTRL_PERF_EN`, `instr_count` is +1 and `cycle_count` is +2.
